// File: rtl/pattern_seq_pkg.sv
// Shared types and default sizing for the pattern sequencer.
package pattern_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_CH    = 2;
  localparam int DEF_STEPS = 4;
  localparam int DEF_CW    = 5;

endpackage

// File: rtl/pattern_seq_step_timer.sv
// step_timer: CW-bit step counter with duration load, clear and terminal-count flag.
// The live count is exported only when PATTERN_SEQ_DBG_EN is defined.
module step_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic          en,
  input  logic [CW-1:0] ld_val,
  output logic          tc
`ifdef PATTERN_SEQ_DBG_EN
  ,
  output logic [CW-1:0] cnt
`endif
);

`ifndef PATTERN_SEQ_DBG_EN
  logic [CW-1:0] cnt;
`endif
  logic [CW-1:0] dur_r;

  // dur_r holds the captured duration so later input changes cannot stretch a step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      dur_r <= '0;
    end else if (clr) begin
      cnt   <= '0;
      dur_r <= '0;
    end else if (ld) begin
      cnt   <= '0;
      dur_r <= ld_val;
    end else if (en) begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == dur_r);

endmodule

// File: rtl/pattern_seq.sv
// pattern_seq: steps through STEPS (duration, level) pairs, one-shot or looping.
// Define PATTERN_SEQ_DBG_EN to drive dbg_step/dbg_cnt with live state; otherwise they are 0.
module pattern_seq
  import pattern_seq_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int STEPS = DEF_STEPS,
  parameter int CW    = DEF_CW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [STEPS*CW-1:0]      dur,
  input  logic [STEPS*CH-1:0]      lvl,
  output logic [CH-1:0]            q,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(STEPS)-1:0] dbg_step,
  output logic [CW-1:0]            dbg_cnt
);

  localparam int SW = $clog2(STEPS);
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  // Handshake: start is a single-cycle request honoured only in IDLE with stop low;
  // stop aborts RUN on the next edge and always wins over start and over completion.

  state_t        state, state_nxt;
  logic [SW-1:0] step, step_nxt, step_inc;
  logic [CH-1:0] q_nxt;
  logic          done_nxt;
  logic          t_clr, t_ld, t_en, t_tc;
  logic [CW-1:0] t_ld_val;
  logic [CW-1:0] dur_a [STEPS];
  logic [CH-1:0] lvl_a [STEPS];

  for (genvar k = 0; k < STEPS; k++) begin : g_unpack
    assign dur_a[k] = dur[k*CW +: CW];
    assign lvl_a[k] = lvl[k*CH +: CH];
  end

  assign step_inc = step + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !stop) state_nxt = RUN;
      RUN: begin
        if (stop)                               state_nxt = IDLE;
        else if (t_tc && step == LAST && !loop_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    t_clr    = 1'b0;
    t_ld     = 1'b0;
    t_en     = 1'b0;
    t_ld_val = dur_a[0];
    step_nxt = step;
    q_nxt    = q;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        step_nxt = '0;
        if (start && !stop) begin
          t_ld  = 1'b1;
          q_nxt = lvl_a[0];
        end else begin
          t_clr = 1'b1;
          q_nxt = '0;
        end
      end
      RUN: begin
        if (stop) begin
          t_clr    = 1'b1;
          step_nxt = '0;
          q_nxt    = '0;
        end else if (t_tc) begin
          // loop_en only matters here, at the last-step boundary
          if (step == LAST) begin
            step_nxt = '0;
            if (loop_en) begin
              t_ld  = 1'b1;
              q_nxt = lvl_a[0];
            end else begin
              t_clr    = 1'b1;
              q_nxt    = '0;
              done_nxt = 1'b1;
            end
          end else begin
            t_ld     = 1'b1;
            t_ld_val = dur_a[step_inc];
            step_nxt = step_inc;
            q_nxt    = lvl_a[step_inc];
          end
        end else begin
          t_en = 1'b1;
        end
      end
      default: begin
        t_clr    = 1'b1;
        step_nxt = '0;
        q_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= '0;
      q    <= '0;
      done <= 1'b0;
    end else begin
      step <= step_nxt;
      q    <= q_nxt;
      done <= done_nxt;
    end
  end

  step_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (t_clr),
    .ld     (t_ld),
    .en     (t_en),
    .ld_val (t_ld_val),
    .tc     (t_tc)
`ifdef PATTERN_SEQ_DBG_EN
    ,
    .cnt    (dbg_cnt)
`endif
  );

`ifdef PATTERN_SEQ_DBG_EN
  assign dbg_step = step;
`else
  assign dbg_step = '0;
  assign dbg_cnt  = '0;
`endif

endmodule

// File: tb/tb_pattern_seq.sv
// Directed bench for pattern_seq: looping, one-shot, uneven steps, stop, reset, start/stop races.
module tb_pattern_seq;

  localparam int CH    = 2;
  localparam int STEPS = 4;
  localparam int CW    = 5;
  localparam int SW    = $clog2(STEPS);

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                stop;
  logic                loop_en;
  logic [STEPS*CW-1:0] dur;
  logic [STEPS*CH-1:0] lvl;
  logic [CH-1:0]       q;
  logic                busy;
  logic                done;
  logic [SW-1:0]       dbg_step;
  logic [CW-1:0]       dbg_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [STEPS*CW-1:0] DUR_ALL9 = {5'd9, 5'd9, 5'd9, 5'd9};
  localparam logic [STEPS*CH-1:0] LVL_ALT  = {2'b00, 2'b01, 2'b00, 2'b01};

  // clock / reset
  always #5 clk = ~clk;

  pattern_seq #(.CH(CH), .STEPS(STEPS), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .dur      (dur),
    .lvl      (lvl),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .dbg_step (dbg_step),
    .dbg_cnt  (dbg_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dbg_exp(input int v);
`ifdef PATTERN_SEQ_DBG_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_q"},    32'(q),    32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int exp_step [9] = '{0, 1, 1, 1, 1, 2, 3, 3, 0};
    int exp_cnt  [9] = '{0, 0, 1, 2, 3, 0, 0, 1, 0};
    logic [31:0] e;

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    dur = '0; lvl = '0;
    tick(); tick();
    check_idle("reset");
    check("reset_dbg_step", 32'(dbg_step), 32'd0);
    check("reset_dbg_cnt",  32'(dbg_cnt),  32'd0);
    rst = 1'b0;
    tick(); tick();
    check_idle("post_reset");

    // looping: q[0] toggles every 10 cycles across 3 full wraps; loop_en glitch mid-step is ignored
    dur = DUR_ALL9; lvl = LVL_ALT; loop_en = 1'b1;
    pulse_start();
    for (int i = 1; i <= 130; i++) begin
      check("loop_q0",   32'(q[0]), (((i - 1) / 10) % 2 == 0) ? 32'd1 : 32'd0);
      check("loop_busy", 32'(busy), 32'd1);
      loop_en = (i >= 50 && i <= 55) ? 1'b0 : 1'b1;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("loop_stop");

    // one-shot: 40 busy cycles, then a single done pulse
    loop_en = 1'b0;
    tick();
    pulse_start();
    for (int i = 1; i <= 40; i++) begin
      check("oneshot_q0",   32'(q[0]), (((i - 1) / 10) % 2 == 0) ? 32'd1 : 32'd0);
      check("oneshot_busy", 32'(busy), 32'd1);
      check("oneshot_done", 32'(done), 32'd0);
      tick();
    end
    check("oneshot_done_pulse", 32'(done), 32'd1);
    check("oneshot_end_busy",   32'(busy), 32'd0);
    check("oneshot_end_q",      32'(q),    32'd0);
    tick();
    check("oneshot_done_clear", 32'(done), 32'd0);

    // uneven steps 1,4,1,2 cycles, tracked via distinct levels and debug outputs
    dur = {5'd1, 5'd0, 5'd3, 5'd0};
    lvl = {2'b01, 2'b11, 2'b10, 2'b01};
    exp_q = '{32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd3, 32'd1, 32'd1, 32'd0};
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      check("steps_q",        32'(q),        e);
      check("steps_busy",     32'(busy),     (i < 8) ? 32'd1 : 32'd0);
      check("steps_done",     32'(done),     (i == 8) ? 32'd1 : 32'd0);
      check("steps_dbg_step", 32'(dbg_step), dbg_exp(exp_step[i]));
      check("steps_dbg_cnt",  32'(dbg_cnt),  dbg_exp(exp_cnt[i]));
      tick();
    end

    // stop at cycle 15: IDLE next cycle, no done afterwards
    dur = DUR_ALL9; lvl = '1; loop_en = 1'b0;
    pulse_start();
    for (int i = 1; i < 15; i++) tick();
    check("stop_q_before",    32'(q),    32'd3);
    check("stop_busy_before", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("stop_after");
    for (int i = 0; i < 40; i++) begin
      check("stop_no_done", 32'(done), 32'd0);
      tick();
    end

    // asynchronous reset during step 2, then restart from step 0
    lvl = {2'b01, 2'b11, 2'b10, 2'b01}; loop_en = 1'b1;
    pulse_start();
    for (int i = 1; i < 25; i++) tick();
    check("rst_q_step2",   32'(q),        32'd3);
    check("rst_dbg_step2", 32'(dbg_step), dbg_exp(2));
    #1 rst = 1'b1;
    #1;
    check_idle("rst_async");
    check("rst_async_dbg_step", 32'(dbg_step), 32'd0);
    check("rst_async_dbg_cnt",  32'(dbg_cnt),  32'd0);
    #1 rst = 1'b0;
    tick(); tick();
    check_idle("rst_wait");
    pulse_start();
    for (int i = 1; i <= 10; i++) begin
      check("rst_restart_q",    32'(q),        32'd1);
      check("rst_restart_step", 32'(dbg_step), dbg_exp(0));
      tick();
    end
    check("rst_restart_step1_q", 32'(q), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("rst_restart_stop");

    // start with stop in IDLE is refused
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_idle("start_stop_idle");
    tick();
    check("start_stop_idle_hold", 32'(busy), 32'd0);

    // start pulses during RUN leave the one-shot timing unchanged
    dur = DUR_ALL9; lvl = LVL_ALT; loop_en = 1'b0;
    pulse_start();
    for (int i = 1; i <= 40; i++) begin
      check("rerun_q0",   32'(q[0]), (((i - 1) / 10) % 2 == 0) ? 32'd1 : 32'd0);
      check("rerun_busy", 32'(busy), 32'd1);
      check("rerun_done", 32'(done), 32'd0);
      start = (i == 5 || i == 25) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    check("rerun_done_pulse", 32'(done), 32'd1);
    check("rerun_end_busy",   32'(busy), 32'd0);
    tick();
    check_idle("rerun_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
